// File: rtl/requant_relu_stage_if.sv
// Stream bundle between the conv MAC array, the requant stage and maxpool_engine.
//
// Handshake: valid-only, no backpressure. A beat transfers on every rising clk
// edge where valid_in (or valid_out) is high; the sink must accept it. Gaps are
// allowed. Data and config are only meaningful in a cycle where valid is high.
interface requant_relu_stage_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int MULT_WIDTH = 16
);
  logic                         valid_in;
  logic signed [ACC_WIDTH-1:0]  acc_in;
  logic signed [ACC_WIDTH-1:0]  bias;
  logic        [MULT_WIDTH-1:0] mult;
  logic        [4:0]            shift;
  logic                         relu_en;
  logic                         valid_out;
  logic signed [7:0]            pixel_out;
  logic                         all_done;

  modport master (
    output valid_in, acc_in, bias, mult, shift, relu_en,
    input  valid_out, pixel_out, all_done
  );

  modport slave (
    input  valid_in, acc_in, bias, mult, shift, relu_en,
    output valid_out, pixel_out, all_done
  );
endinterface

// File: rtl/requant_relu_stage.sv
// Requantization stage: bias add, fixed-point scale with round-half-up shift,
// optional ReLU and int8 saturation, in a 3-register pipeline. Config is
// captured on the first beat of each frame and travels with each beat so a
// new frame can start while the previous frame's tail is still in flight.
module requant_relu_stage #(
  parameter int ACC_WIDTH  = 32,
  parameter int MULT_WIDTH = 16,
  parameter int MAP_WIDTH  = 28
) (
  input logic                  clk,
  input logic                  rst_n,
  requant_relu_stage_if.slave  bus
);
  localparam int FRAME = MAP_WIDTH * MAP_WIDTH;
  localparam int CW    = $clog2(FRAME);
  localparam int SW    = ACC_WIDTH + 1;
  localparam int PW    = ACC_WIDTH + MULT_WIDTH + 1;
  localparam int RW    = PW + 1;
  localparam logic [CW-1:0]        LAST    = CW'(FRAME - 1);
  localparam logic signed [RW-1:0] POS_MAX = 127;
  localparam logic signed [RW-1:0] NEG_MIN = -128;

  logic [CW-1:0]                 in_cnt, out_cnt;
  logic signed [ACC_WIDTH-1:0]   cfg_bias;
  logic        [MULT_WIDTH-1:0]  cfg_mult;
  logic        [4:0]             cfg_shift;
  logic                          cfg_relu;

  logic                          first_beat;
  logic signed [ACC_WIDTH-1:0]   eff_bias;
  logic        [MULT_WIDTH-1:0]  eff_mult;
  logic        [4:0]             eff_shift;
  logic                          eff_relu;

  logic                          v1, v2, v3;
  logic signed [SW-1:0]          s1;
  logic        [MULT_WIDTH-1:0]  mult1;
  logic        [4:0]             shift1, shift2;
  logic                          relu1, relu2;
  logic signed [PW-1:0]          p2;
  logic signed [PW-1:0]          s_ext, m_ext;

  logic        [RW-1:0]          round_inc;
  logic signed [RW-1:0]          r_ext, r_sum, r_shift, r_relu;
  logic        [7:0]             pix_next, pix3;
  logic                          done_pend, done_q;

  // Frame-start beat uses the live config; later beats use the latched copy.
  always_comb begin
    first_beat = bus.valid_in && (in_cnt == '0);
    eff_bias   = first_beat ? bus.bias    : cfg_bias;
    eff_mult   = first_beat ? bus.mult    : cfg_mult;
    eff_shift  = first_beat ? bus.shift   : cfg_shift;
    eff_relu   = first_beat ? bus.relu_en : cfg_relu;
  end

  // Input beat counter and per-frame config latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      cfg_bias  <= '0;
      cfg_mult  <= '0;
      cfg_shift <= '0;
      cfg_relu  <= 1'b0;
    end else if (bus.valid_in) begin
      in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + CW'(1);
      if (first_beat) begin
        cfg_bias  <= bus.bias;
        cfg_mult  <= bus.mult;
        cfg_shift <= bus.shift;
        cfg_relu  <= bus.relu_en;
      end
    end
  end

  // S1: widened bias add, so the sum can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; s1 <= '0; mult1 <= '0; shift1 <= '0; relu1 <= 1'b0;
    end else begin
      v1 <= bus.valid_in;
      if (bus.valid_in) begin
        s1     <= {bus.acc_in[ACC_WIDTH-1], bus.acc_in} + {eff_bias[ACC_WIDTH-1], eff_bias};
        mult1  <= eff_mult;
        shift1 <= eff_shift;
        relu1  <= eff_relu;
      end
    end
  end

  // Multiplier is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    s_ext = PW'(s1);
    m_ext = PW'({1'b0, mult1});
  end

  // S2: exact signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; p2 <= '0; shift2 <= '0; relu2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p2     <= s_ext * m_ext;
        shift2 <= shift1;
        relu2  <= relu1;
      end
    end
  end

  // Round-half-up shift in one extra bit, then ReLU, then clamp to int8.
  always_comb begin
    r_ext     = RW'(p2);
    round_inc = (shift2 == 5'd0) ? '0 : (RW'(1) << (shift2 - 5'd1));
    r_sum     = r_ext + $signed(round_inc);
    r_shift   = r_sum >>> shift2;
    r_relu    = (relu2 && r_shift[RW-1]) ? '0 : r_shift;
    if (r_relu > POS_MAX)      pix_next = 8'h7f;
    else if (r_relu < NEG_MIN) pix_next = 8'h80;
    else                       pix_next = r_relu[7:0];
  end

  // S3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      pix3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) pix3 <= pix_next;
    end
  end

  // Output counter; all_done is set one edge after the last output of a frame
  // and that set wins over a same-edge clear from a new frame's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt   <= '0;
      done_pend <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (v2) out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + CW'(1);
      done_pend <= v2 && (out_cnt == LAST);
      if (done_pend)       done_q <= 1'b1;
      else if (first_beat) done_q <= 1'b0;
    end
  end

  assign bus.valid_out = v3;
  assign bus.pixel_out = pix3;
  assign bus.all_done  = done_q;
endmodule
